// File: rtl/project_sel_ctrl_if.sv
// Host-side Wishbone slave bus of project_sel_ctrl; signal names match the legacy flat ports.
interface project_sel_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/project_sel_ctrl.sv
// Active-project select, round-robin scheduler, CSR window and Wishbone forwarding
// with a watchdog that terminates hung project transactions.
module project_sel_ctrl #(
    parameter int unsigned USER_PROJECTS = 4,
    parameter int unsigned SEL_BITS      = 2,
    parameter logic [31:0] CSR_BASE      = 32'h300FFFF0,
    parameter int unsigned TIMEOUT       = 255,
    parameter logic [31:0] TO_DATA       = 32'hDEADBEEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    project_sel_ctrl_if.slave   wbs,
    input  logic                proj_ack_i,
    input  logic [31:0]         proj_dat_i,
    output logic [SEL_BITS-1:0] proj_sel_o,
    output logic                switch_o,
    output logic                irq_o
);

    typedef enum logic [1:0] {IDLE, CSR_ACK, FWD, TO_ACK} state_t;

    state_t              state_q, state_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic [15:0]         period_q, period_d;
    logic [7:0]          to_cnt_q, to_cnt_d;
    logic                sticky_q, sticky_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [7:0]          wd_q, wd_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic                switch_q, switch_d;

    logic        req, csr_hit, csr_wr, sel_ok, bus_idle, due;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[1:0]};

    always_comb begin
        req      = wbs.wbs_cyc_i & wbs.wbs_stb_i;
        csr_hit  = req && (wbs.wbs_adr_i[31:4] == CSR_BASE[31:4]);
        off      = wbs.wbs_adr_i[3:2];
        csr_wr   = (state_q == IDLE) && csr_hit && wbs.wbs_we_i;
        sel_ok   = csr_wr && (off == 2'd1) && (wbs.wbs_dat_i < USER_PROJECTS);
        bus_idle = (state_q == IDLE) && !wbs.wbs_cyc_i;
        // The slot's last count cycle already counts as due so an idle bus switches
        // exactly every PERIOD cycles; the pending flag only carries it past a busy bus.
        due      = pend_q || (cnt_q == period_q - 16'd1);

        case (off)
            2'd0:    rdata = {30'd0, ctrl_q};
            2'd1:    rdata = 32'(sel_q);
            2'd2:    rdata = {16'd0, period_q};
            default: rdata = {23'd0, sticky_q, to_cnt_q};
        endcase

        state_d  = state_q;
        sel_d    = sel_q;
        ctrl_d   = ctrl_q;
        period_d = period_q;
        to_cnt_d = to_cnt_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        wd_d     = '0;
        ack_d    = 1'b0;
        dat_d    = '0;

        case (state_q)
            IDLE: begin
                if (csr_hit) begin
                    state_d = CSR_ACK;
                    ack_d   = 1'b1;
                    dat_d   = rdata;
                end else if (req) begin
                    state_d = FWD;
                end
            end
            CSR_ACK: state_d = IDLE;
            FWD: begin
                // A project ack in the expiry cycle wins over the watchdog.
                if (proj_ack_i || !req) begin
                    state_d = IDLE;
                end else if (wd_q == 8'(TIMEOUT - 1)) begin
                    state_d  = TO_ACK;
                    ack_d    = 1'b1;
                    dat_d    = TO_DATA;
                    sticky_d = 1'b1;
                    if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            TO_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (csr_wr) begin
            case (off)
                2'd0: ctrl_d = wbs.wbs_dat_i[1:0];
                2'd2: period_d = wbs.wbs_dat_i[15:0];
                2'd3: begin
                    sticky_d = 1'b0;
                    to_cnt_d = '0;
                end
                default: ;
            endcase
        end

        if ((csr_wr && (off == 2'd0 || off == 2'd2)) || sel_ok) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (sel_ok) sel_d = wbs.wbs_dat_i[SEL_BITS-1:0];
        end else if (!ctrl_q[0] || period_q == 16'd0) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (due && bus_idle) begin
            sel_d  = (sel_q == SEL_BITS'(USER_PROJECTS - 1)) ? '0 : sel_q + SEL_BITS'(1);
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (due) begin
            pend_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        switch_d = (sel_d != sel_q);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            ctrl_q   <= '0;
            period_q <= '0;
            to_cnt_q <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            wd_q     <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            to_cnt_q <= to_cnt_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            wd_q     <= wd_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            switch_q <= switch_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q | ((state_q == FWD) & proj_ack_i);
    assign wbs.wbs_dat_o = (state_q == FWD) ? proj_dat_i : dat_q;
    assign proj_sel_o    = sel_q;
    assign switch_o      = switch_q;
    assign irq_o         = sticky_q & ctrl_q[1];

endmodule

// File: doc/project_sel_ctrl.md
Name: project_sel_ctrl

Overview:
Control and scheduling block for the multi-project user area. It owns the active-project select that drives the project output muxes, and it can switch projects manually or round-robin on a programmable period. Switches happen only between Wishbone transactions. It also answers its own CSR window, forwards all other Wishbone traffic to the selected project, and terminates hung project transactions with a watchdog.

Parameters:
USER_PROJECTS, 4, number of selectable projects (2..16)
SEL_BITS, 2, width of select; must equal clog2(USER_PROJECTS)
CSR_BASE, 32'h300FFFF0, base of the 16-byte CSR window (4 words)
TIMEOUT, 255, cycles without project ack before the watchdog terminates the transaction (1..255)
TO_DATA, 32'hDEADBEEF, read data returned on a watchdog-terminated cycle

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
wbs_cyc_i  in  1  WB cycle
wbs_stb_i  in  1  WB strobe
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  byte enables; ignored, all CSR writes are full-word
wbs_adr_i  in  32  WB address
wbs_dat_i  in  32  WB write data
wbs_ack_o  out  1  ack to host: CSR ack, watchdog ack, or forwarded project ack
wbs_dat_o  out  32  read data to host
proj_ack_i  in  1  ack from the currently selected project (muxed externally)
proj_dat_i  in  32  read data from the currently selected project
proj_sel_o  out  SEL_BITS  active project index
switch_o  out  1  one-cycle pulse on the cycle after proj_sel_o changes
irq_o  out  1  level interrupt: timeout sticky AND irq_en

Behaviour:
- Reset (async, wb_rst_i=1) clears: proj_sel_o=0, CTRL=0, PERIOD=0, STATUS=0, period counter=0, watchdog=0, FSM=IDLE, wbs_ack_o=0, wbs_dat_o=0, switch_o=0, irq_o=0. Reset mid-transaction abandons it; no ack is issued.
- CSR hit: cyc&stb & adr[31:4]==CSR_BASE[31:4]. Word offset is adr[3:2].
- CSR map:
  - 0x0 CTRL: [0] auto_en, [1] irq_en.
  - 0x4 SEL: write requests a select; read returns proj_sel_o.
  - 0x8 PERIOD: [15:0], cycles per slot.
  - 0xC STATUS: [7:0] timeout count (saturates at 255), [8] timeout sticky; any write clears both.
  - Unused bits read 0.
- Bus FSM states IDLE, CSR_ACK, FWD, TO_ACK:
  - IDLE → CSR_ACK on CSR hit. The register write takes effect on the transition. wbs_ack_o=1 for exactly one cycle in CSR_ACK, with registered read data. Then → IDLE. Latency is 1 cycle. A held stb re-enters CSR_ACK only after one IDLE cycle, so there are no double acks.
  - IDLE → FWD on cyc&stb without a CSR hit. In FWD, wbs_ack_o=proj_ack_i and wbs_dat_o=proj_dat_i combinationally. The watchdog increments each cycle without proj_ack_i. On proj_ack_i, or if cyc/stb drops → IDLE, and the watchdog clears.
  - FWD → TO_ACK when the watchdog reaches TIMEOUT and proj_ack_i=0. TO_ACK asserts wbs_ack_o for one cycle with wbs_dat_o=TO_DATA, sets sticky, and increments count. → IDLE.
  - proj_ack_i and timeout in the same cycle: the project ack wins; no timeout is recorded.
  - wbs_dat_o=0 in IDLE.
- Scheduler:
  - When auto_en=1 and PERIOD≠0, the period counter increments each cycle.
  - At count==PERIOD-1 it sets switch_pending and holds.
  - The pending switch is applied in a cycle with FSM=IDLE and wbs_cyc_i=0: proj_sel_o increments, wrapping USER_PROJECTS-1→0, the counter clears, and pending clears.
  - PERIOD=0 or auto_en=0: the counter and pending are held at 0.
  - Any CTRL or PERIOD write clears the counter and pending.
- Manual select: a SEL write with value < USER_PROJECTS updates proj_sel_o on entry to CSR_ACK, and clears the counter and pending. A value ≥ USER_PROJECTS is ignored but still acked.
- A manual write and a pending auto switch in the same cycle: the manual write wins and pending is dropped.
- switch_o pulses once per actual change. Writing the current value gives no pulse.

Test Plan:
- Reset, then read 0x300FFFF4 → ack 1 cycle after stb, data 0; proj_sel_o=0, irq_o=0.
- Write SEL=2, then SEL=7 → proj_sel_o=2 with one switch_o pulse; after the second write it stays 2, is acked, and there is no pulse.
- PERIOD=10, CTRL=1, bus idle → proj_sel_o steps 0→1→2→3→0 every 10 cycles, one switch_o per step.
- Auto switch due while a forwarded read is held with proj_ack_i delayed 20 cycles → proj_sel_o unchanged until cyc drops, then increments on the first idle cycle.
- Forwarded read with proj_ack_i never asserted, TIMEOUT=255, irq_en=1 → ack on cycle 256 with data DEADBEEF; STATUS=0x101, irq_o=1; write STATUS → 0, irq_o=0.
- proj_ack_i asserted on exactly the TIMEOUT cycle → project data returned, STATUS stays 0; assert reset mid-FWD → no ack, all outputs 0.
